// File: rtl/mem_rmw_ctrl_pkg.sv
// Shared core definitions for the load/store sequencer: widths, memory opcodes
// and the sequencer state encoding.
package mem_rmw_ctrl_pkg;

    localparam int CPU_WIDTH    = 32;
    localparam int MEM_OP_WIDTH = 4;

    typedef logic [MEM_OP_WIDTH-1:0] mem_op_t;

    localparam mem_op_t MEM_LB  = 4'd0;
    localparam mem_op_t MEM_LH  = 4'd1;
    localparam mem_op_t MEM_LW  = 4'd2;
    localparam mem_op_t MEM_LBU = 4'd3;
    localparam mem_op_t MEM_LHU = 4'd4;
    localparam mem_op_t MEM_SB  = 4'd5;
    localparam mem_op_t MEM_SH  = 4'd6;
    localparam mem_op_t MEM_SW  = 4'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_MERGE  = 3'd2,
        ST_LDRESP = 3'd3,
        ST_WRITE  = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    // True for encodings outside the opcode set or accesses not naturally aligned.
    function automatic logic access_bad(input mem_op_t op, input logic [1:0] addr_lo);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 1'b0;
            MEM_LH, MEM_LHU, MEM_SH: return addr_lo[0];
            MEM_LW, MEM_SW:          return |addr_lo;
            default:                 return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_rmw_ctrl_if.sv
// Bus between the execute stage, the load/store sequencer and the data RAM.
interface mem_rmw_ctrl_if #(parameter int RAM_AW = 12);
    import mem_rmw_ctrl_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    mem_op_t              mem_op;
    logic [CPU_WIDTH-1:0] mem_addr;
    logic [CPU_WIDTH-1:0] reg2_rdata;
    logic                 resp_valid;
    logic [CPU_WIDTH-1:0] load_data;
    logic                 misalign_err;
    logic                 ram_en;
    logic                 ram_we;
    logic [RAM_AW-1:0]    ram_addr;
    logic [CPU_WIDTH-1:0] ram_wdata;
    logic [CPU_WIDTH-1:0] ram_rdata;

    modport master (
        output req_valid, mem_op, mem_addr, reg2_rdata, ram_rdata,
        input  req_ready, resp_valid, load_data, misalign_err,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  req_valid, mem_op, mem_addr, reg2_rdata, ram_rdata,
        output req_ready, resp_valid, load_data, misalign_err,
               ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/mem_load_ext.sv
// Selects the addressed byte/half from a RAM word and sign- or zero-extends it.
module mem_load_ext
    import mem_rmw_ctrl_pkg::*;
(
    input  mem_op_t              mem_op,
    input  logic [1:0]           addr_lo,
    input  logic [CPU_WIDTH-1:0] rdata,
    output logic [CPU_WIDTH-1:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{addr_lo, 3'b000} +: 8];
        half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];
        case (mem_op)
            MEM_LB:  data = {{(CPU_WIDTH-8){byte_lane[7]}}, byte_lane};
            MEM_LBU: data = {{(CPU_WIDTH-8){1'b0}}, byte_lane};
            MEM_LH:  data = {{(CPU_WIDTH-16){half_lane[15]}}, half_lane};
            MEM_LHU: data = {{(CPU_WIDTH-16){1'b0}}, half_lane};
            MEM_LW:  data = rdata;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_rmw_ctrl.sv
// Load/store sequencer in front of a single-port synchronous data RAM; byte and
// half stores are done as read-modify-write of the containing word.
module mem_rmw_ctrl
    import mem_rmw_ctrl_pkg::*;
#(
    parameter int RAM_AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    mem_rmw_ctrl_if.slave bus
);

    state_t               state;
    mem_op_t              op_q;
    logic [CPU_WIDTH-1:0] addr_q;
    logic [CPU_WIDTH-1:0] data_q;
    logic [CPU_WIDTH-1:0] merged;
    logic [CPU_WIDTH-1:0] ext_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            op_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_q   <= bus.mem_op;
                        addr_q <= bus.mem_addr;
                        data_q <= bus.reg2_rdata;
                        if (access_bad(bus.mem_op, bus.mem_addr[1:0]))
                            state <= ST_ERR;
                        else if (bus.mem_op == MEM_SW)
                            state <= ST_WRITE;
                        else
                            state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (op_q == MEM_SB || op_q == MEM_SH)
                        state <= ST_MERGE;
                    else
                        state <= ST_LDRESP;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mem_load_ext u_load_ext (
        .mem_op  (op_q),
        .addr_lo (addr_q[1:0]),
        .rdata   (bus.ram_rdata),
        .data    (ext_data)
    );

    // The read word arrives in the MERGE cycle itself, so the merge is combinational.
    always_comb begin
        merged = bus.ram_rdata;
        if (op_q == MEM_SB)
            merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
    end

    always_comb begin
        bus.req_ready    = (state == ST_IDLE);
        bus.resp_valid   = 1'b0;
        bus.load_data    = '0;
        bus.misalign_err = 1'b0;
        bus.ram_en       = 1'b0;
        bus.ram_we       = 1'b0;
        bus.ram_addr     = '0;
        bus.ram_wdata    = '0;
        case (state)
            ST_READ: begin
                bus.ram_en   = 1'b1;
                bus.ram_addr = addr_q[RAM_AW+1:2];
            end
            ST_MERGE: begin
                bus.ram_en     = 1'b1;
                bus.ram_we     = 1'b1;
                bus.ram_addr   = addr_q[RAM_AW+1:2];
                bus.ram_wdata  = merged;
                bus.resp_valid = 1'b1;
            end
            ST_WRITE: begin
                bus.ram_en     = 1'b1;
                bus.ram_we     = 1'b1;
                bus.ram_addr   = addr_q[RAM_AW+1:2];
                bus.ram_wdata  = data_q;
                bus.resp_valid = 1'b1;
            end
            ST_LDRESP: begin
                bus.resp_valid = 1'b1;
                bus.load_data  = ext_data;
            end
            ST_ERR: begin
                bus.resp_valid   = 1'b1;
                bus.misalign_err = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Scoreboard bench for mem_rmw_ctrl with a behavioural synchronous RAM.
module tb_mem_rmw_ctrl;
    import mem_rmw_ctrl_pkg::*;

    localparam int RAM_AW = 12;

    typedef struct {
        string       name;
        logic [31:0] exp_load;
        logic        exp_err;
        logic        exp_write;
        logic        exp_read;
        logic [11:0] exp_waddr;
        logic [31:0] exp_wdata;
        int          exp_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   we_count = 0;
    int   en_count = 0;
    int   idle_bad = 0;
    logic        prev_rd_valid = 1'b0;
    logic [11:0] prev_rd_addr = '0;
    exp_t sb_q[$];

    logic [31:0] ram [0:(1<<RAM_AW)-1];

    mem_rmw_ctrl_if #(.RAM_AW(RAM_AW)) bus ();

    mem_rmw_ctrl #(.RAM_AW(RAM_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata     <= ram[bus.ram_addr];
        end
    end

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else
            passes++;
    endtask

    // Monitor: pops one expectation per response and compares everything visible.
    always @(negedge clk) begin
        if (bus.ram_en && bus.ram_we) we_count++;
        if (bus.ram_en) en_count++;
        if (!bus.resp_valid && (bus.load_data != 0 || bus.misalign_err)) idle_bad++;
        if (!bus.ram_en && (bus.ram_we || bus.ram_addr != 0 || bus.ram_wdata != 0)) idle_bad++;
        if (bus.resp_valid) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val({e.name, ".latency"}, cyc, e.exp_cyc);
                check_val({e.name, ".load_data"}, bus.load_data, e.exp_load);
                check_val({e.name, ".misalign_err"}, {31'd0, bus.misalign_err}, {31'd0, e.exp_err});
                check_val({e.name, ".ram_en"}, {31'd0, bus.ram_en}, {31'd0, e.exp_write});
                check_val({e.name, ".ram_we"}, {31'd0, bus.ram_we}, {31'd0, e.exp_write});
                if (e.exp_write) begin
                    check_val({e.name, ".ram_addr"}, {20'd0, bus.ram_addr}, {20'd0, e.exp_waddr});
                    check_val({e.name, ".ram_wdata"}, bus.ram_wdata, e.exp_wdata);
                end
                if (e.exp_read) begin
                    check_val({e.name, ".read_strobe"}, {31'd0, prev_rd_valid}, 32'd1);
                    check_val({e.name, ".read_addr"}, {20'd0, prev_rd_addr}, {20'd0, e.exp_waddr});
                end
            end
        end
        prev_rd_valid = bus.ram_en && !bus.ram_we;
        prev_rd_addr  = bus.ram_addr;
    end

    // Drives one request, pushes its expected response, returns in the cycle after acceptance.
    task automatic apply_stimulus(input string name, input mem_op_t op, input logic [31:0] addr,
                                  input logic [31:0] data, input logic [31:0] exp_load,
                                  input logic exp_err, input logic [31:0] exp_wdata, input bit track);
        int   waited = 0;
        exp_t e;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.mem_op     = op;
        bus.mem_addr   = addr;
        bus.reg2_rdata = data;
        while (!bus.req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            check_val({name, ".accept_timeout"}, 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        if (track) begin
            e.name      = name;
            e.exp_load  = exp_load;
            e.exp_err   = exp_err;
            e.exp_write = !exp_err && (op == MEM_SB || op == MEM_SH || op == MEM_SW);
            e.exp_read  = !exp_err && (op != MEM_SW);
            e.exp_waddr = addr[13:2];
            e.exp_wdata = exp_wdata;
            e.exp_cyc   = cyc + ((exp_err || op == MEM_SW) ? 1 : 2);
            sb_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.mem_op     = MEM_SW;
        bus.mem_addr   = 32'h0000_03FC;
        bus.reg2_rdata = 32'hA5A5_A5A5;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int en0;
        int wc0;
        int drain;
        bus.req_valid  = 1'b1;
        bus.mem_op     = MEM_SW;
        bus.mem_addr   = 32'h0000_0010;
        bus.reg2_rdata = 32'h1234_5678;

        // Reset held with a pending request: nothing may be accepted.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val("reset.req_ready", {31'd0, bus.req_ready}, 32'd1);
            check_val("reset.resp_valid", {31'd0, bus.resp_valid}, 32'd0);
            check_val("reset.ram_en", {31'd0, bus.ram_en}, 32'd0);
        end
        rst = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_val("post_reset.ram_en", {31'd0, bus.ram_en}, 32'd0);

        apply_stimulus("sw_10", MEM_SW, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 32'hDEADBEEF, 1);
        apply_stimulus("sw_10b", MEM_SW, 32'h10, 32'h11223344, 32'h0, 1'b0, 32'h11223344, 1);
        apply_stimulus("sb_12", MEM_SB, 32'h12, 32'h000000AA, 32'h0, 1'b0, 32'h11AA3344, 1);
        apply_stimulus("sh_12", MEM_SH, 32'h12, 32'h0000BEEF, 32'h0, 1'b0, 32'hBEEF3344, 1);

        apply_stimulus("sw_20", MEM_SW, 32'h20, 32'h80FF7F01, 32'h0, 1'b0, 32'h80FF7F01, 1);
        apply_stimulus("lb_22",  MEM_LB,  32'h22, 32'h0, 32'hFFFFFFFF, 1'b0, 32'h0, 1);
        apply_stimulus("lbu_22", MEM_LBU, 32'h22, 32'h0, 32'h000000FF, 1'b0, 32'h0, 1);
        apply_stimulus("lh_22",  MEM_LH,  32'h22, 32'h0, 32'hFFFF80FF, 1'b0, 32'h0, 1);
        apply_stimulus("lhu_20", MEM_LHU, 32'h20, 32'h0, 32'h00007F01, 1'b0, 32'h0, 1);
        apply_stimulus("lw_20",  MEM_LW,  32'h20, 32'h0, 32'h80FF7F01, 1'b0, 32'h0, 1);
        apply_stimulus("lb_20",  MEM_LB,  32'h20, 32'h0, 32'h00000001, 1'b0, 32'h0, 1);
        apply_stimulus("lbu_23", MEM_LBU, 32'h23, 32'h0, 32'h00000080, 1'b0, 32'h0, 1);
        apply_stimulus("lh_20",  MEM_LH,  32'h20, 32'h0, 32'h00007F01, 1'b0, 32'h0, 1);

        #1;
        en0 = en_count;
        apply_stimulus("lw_21_mis", MEM_LW, 32'h21, 32'h0, 32'h0, 1'b1, 32'h0, 1);
        apply_stimulus("sh_13_mis", MEM_SH, 32'h13, 32'h0000CAFE, 32'h0, 1'b1, 32'h0, 1);
        apply_stimulus("illegal_op", 4'hF, 32'h10, 32'h0, 32'h0, 1'b1, 32'h0, 1);
        @(negedge clk);
        #1;
        check_val("misalign.ram_en_count", en_count, en0);
        apply_stimulus("lw_10_after", MEM_LW, 32'h10, 32'h0, 32'hBEEF3344, 1'b0, 32'h0, 1);

        // SB interrupted by reset while its read is in flight.
        apply_stimulus("sb_20_rst", MEM_SB, 32'h20, 32'h00000055, 32'h0, 1'b0, 32'h0, 0);
        #1;
        wc0 = we_count;
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_mid.req_ready", {31'd0, bus.req_ready}, 32'd1);
        check_val("rst_mid.resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check_val("rst_mid.ram_en", {31'd0, bus.ram_en}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_val("rst_mid.no_write", we_count, wc0);
        apply_stimulus("lw_20_after_rst", MEM_LW, 32'h20, 32'h0, 32'h80FF7F01, 1'b0, 32'h0, 1);

        drain = 0;
        while (sb_q.size() != 0 && drain < 20) begin
            @(negedge clk);
            drain++;
        end
        @(negedge clk);
        check_val("scoreboard_drained", sb_q.size(), 32'd0);
        check_val("idle_outputs_zero", idle_bad, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_rmw_ctrl.md
# mem_rmw_ctrl

- Sequencer between the execute stage and the single-port synchronous data RAM.
- Accepts one load/store request at a time.
- Loads: reads the word and returns the byte/half/word, sign- or zero-extended.
- Stores: SW is a single write. SB/SH are read-modify-write: read the word, merge the new lane(s) into the read data, write back.
- Stalls the pipeline through `req_ready` while busy.

## Interface

- `RAM_AW`, default 12: word-address width of the data RAM; `ram_addr = mem_addr[RAM_AW+1:2]`.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  block idle, request accepted when `req_valid && req_ready`
- `mem_op`  in  `MEM_OP_WIDTH`  memory opcode: `MEM_LB/LH/LW/LBU/LHU/SB/SH/SW`
- `mem_addr`  in  `CPU_WIDTH`  byte address
- `reg2_rdata`  in  `CPU_WIDTH`  store data; low byte/half used for SB/SH
- `resp_valid`  out  1  one-cycle pulse: access complete; no back-pressure
- `load_data`  out  `CPU_WIDTH`  extended load result, valid with `resp_valid`
- `misalign_err`  out  1  with `resp_valid`: misaligned or illegal op, no RAM access made
- `ram_en`  out  1  RAM access strobe
- `ram_we`  out  1  RAM write enable (whole word)
- `ram_addr`  out  `RAM_AW`  RAM word address
- `ram_wdata`  out  `CPU_WIDTH`  RAM write word
- `ram_rdata`  in  `CPU_WIDTH`  RAM read word, valid the cycle after `ram_en && !ram_we`

## Operation

- **Request capture.** `mem_op`, `mem_addr` and `reg2_rdata` are registered on acceptance. Input changes after acceptance are ignored.
- **States:** IDLE, READ, MERGE, LDRESP, WRITE, ERR.
- **From IDLE on accept:**
  - Misaligned or illegal op → ERR. Misaligned means LH/LHU/SH with `addr[0]=1`, or LW/SW with `addr[1:0]≠0`.
  - SW → WRITE.
  - SB/SH → READ, then MERGE.
  - Loads → READ, then LDRESP.
- **Every non-IDLE state** returns to IDLE after one cycle, except READ.
- **READ:** `ram_en=1`, `ram_we=0`.
- **MERGE:**
  - `ram_en=1`, `ram_we=1`, `resp_valid=1`.
  - `ram_wdata` = `ram_rdata` with the addressed lane replaced:
    - SB: byte lane `addr[1:0]` ← `reg2[7:0]`.
    - SH: half lane `addr[1]` ← `reg2[15:0]`.
- **WRITE:** `ram_en=1`, `ram_we=1`, `ram_wdata=reg2`, `resp_valid=1`.
- **LDRESP:**
  - `resp_valid=1`; `load_data` is extracted combinationally from `ram_rdata`.
  - LB/LBU: byte `addr[1:0]`. LH/LHU: half `addr[1]`. LW: full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- **ERR:** `resp_valid=1`, `misalign_err=1`, `load_data=0`, `ram_en=0`.
- **Output defaults:** `load_data=0` and `misalign_err=0` whenever `resp_valid=0`. `ram_*` outputs are 0 when `ram_en=0`.
- **`req_ready=1` only in IDLE.**

## Timing

- **Reset:** state IDLE, all captured registers 0. Outputs after reset: `req_ready=1`, all other outputs 0.
- **Latency.** Request accepted at edge T; `resp_valid` is high in the listed cycle after T:
  - SW: cycle T+1.
  - SB/SH: cycle T+2; the merged write is in that same cycle.
  - Loads: cycle T+2.
  - ERR: cycle T+1.
- **Throughput.** Next acceptance is possible in the cycle after `resp_valid`. Back-to-back SW therefore runs at one per 2 cycles; SB/SH/loads at one per 3.
- **Reset mid-operation** (any state): go to IDLE at that edge, no further RAM strobe, no `resp_valid`.
  - Reset in READ leaves RAM unmodified.
  - Reset asserted in the MERGE/WRITE cycle itself does not suppress that cycle's write, since the outputs are combinational from state.
- **Ordering:** a store followed by a load to the same word returns the stored data. This is guaranteed because a request is accepted only after the previous write completes.
- **`req_valid` while busy:** ignored; the request must be held by the sender.

## Structure

- **Shared define file** (the existing core header) carries:
  - `CPU_WIDTH`, `MEM_OP_WIDTH`;
  - all `MEM_*` opcode encodings;
  - the state encoding for this block.
- **One sub-module, `mem_load_ext`:** combinational lane select plus sign/zero extension of `ram_rdata` by `mem_op` and `addr[1:0]`.
- The FSM, capture registers and store merge stay in `mem_rmw_ctrl`.

## Test plan

- **Reset:** hold `rst` 2 cycles with `req_valid=1` → `req_ready=1`, `resp_valid=0`, `ram_en=0` throughout; nothing accepted.
- **SW:** addr 0x10, data 0xDEADBEEF → at T+1 `ram_en=ram_we=1`, `ram_addr=4`, `ram_wdata=0xDEADBEEF`, `resp_valid=1`.
- **SB RMW:** RAM word 4 = 0x11223344; SB addr 0x12, data 0xAA → READ at T+1, write 0x11AA3344 at T+2. Repeat SH addr 0x12, data 0xBEEF → write 0xBEEF3344.
- **Loads:**
  - Word 0x80FF7F01 at addr 0x20. LB/LBU addr 0x22 → 0xFFFFFFFF / 0x000000FF. LH addr 0x22 → 0xFFFF80FF. LHU addr 0x20 → 0x00007F01. All at T+2.
- **Misalign:** LW addr 0x21 and SH addr 0x13 → `resp_valid` and `misalign_err` at T+1, `ram_en` never asserted, RAM unchanged.
- **Reset mid-op:** SB accepted, `rst` asserted in the READ cycle → no write, no `resp_valid`, IDLE next cycle. A subsequent LW of the same word returns the original value.
